// File: rtl/as13_pkg.sv
// Shared types and constants for the as13 output decoder: code type, the 16
// reference patterns, checker states and the legal set of codes that may follow P6.
package as13_pkg;

  typedef logic [3:0] code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  // y_i lives in bit i-1
  function automatic logic [24:0] ybit(input int unsigned i);
    return 25'd1 << (i - 1);
  endfunction

  localparam logic [24:0] PAT_P0  = 25'd0;
  localparam logic [24:0] PAT_P1  = ybit(11);
  localparam logic [24:0] PAT_P2  = ybit(2) | ybit(4) | ybit(5) | ybit(6) | ybit(7);
  localparam logic [24:0] PAT_P3  = ybit(4) | ybit(5) | ybit(6) | ybit(7) | ybit(14) | ybit(23);
  localparam logic [24:0] PAT_P4  = ybit(9) | ybit(17);
  localparam logic [24:0] PAT_P5  = ybit(4) | ybit(8) | ybit(15) | ybit(16);
  localparam logic [24:0] PAT_P6  = ybit(2) | ybit(3) | ybit(4) | ybit(19);
  localparam logic [24:0] PAT_P7  = ybit(4) | ybit(7) | ybit(8) | ybit(24);
  localparam logic [24:0] PAT_P8  = ybit(2) | ybit(4) | ybit(5) | ybit(6) | ybit(15);
  localparam logic [24:0] PAT_P9  = ybit(9) | ybit(10);
  localparam logic [24:0] PAT_P10 = ybit(3) | ybit(4) | ybit(14) | ybit(21);
  localparam logic [24:0] PAT_P11 = ybit(2) | ybit(4) | ybit(7) | ybit(12);
  localparam logic [24:0] PAT_P12 = ybit(4) | ybit(16) | ybit(18) | ybit(20) | ybit(22);
  localparam logic [24:0] PAT_P13 = ybit(4) | ybit(5) | ybit(6) | ybit(13) | ybit(14);
  localparam logic [24:0] PAT_P14 = ybit(1) | ybit(2) | ybit(18) | ybit(25);
  localparam logic [24:0] PAT_P15 = ybit(2) | ybit(4) | ybit(18) | ybit(20);

  localparam logic [15:0][24:0] PATTERNS = {
    PAT_P15, PAT_P14, PAT_P13, PAT_P12, PAT_P11, PAT_P10, PAT_P9, PAT_P8,
    PAT_P7,  PAT_P6,  PAT_P5,  PAT_P4,  PAT_P3,  PAT_P2,  PAT_P1, PAT_P0
  };

  localparam code_t CODE_P6 = 4'd6;

  // one bit per code: P2..P5 are the only legal successors of P6
  localparam logic [15:0] P6_SUCC_OK = 16'b0000_0000_0011_1100;

endpackage

// File: rtl/as13_pat_match.sv
// Combinational exact-match decoder: y against the 16 reference patterns.
module as13_pat_match
  import as13_pkg::*;
(
  input  logic [24:0] y,
  output logic [3:0]  code,
  output logic        hit
);

  always_comb begin
    code = '0;
    hit  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (y == PATTERNS[i]) begin
        code = code_t'(i);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/as13_out_decoder.sv
// as13 output decoder with P6-successor checker and illegal-run alarm.
// Optional per-code histogram is built when AS13_HIST_EN is defined.
//
// state    | meaning
// ST_IDLE  | no sample seen since reset
// ST_RUN   | decoding, successor and illegal-run checks active
// ST_ALARM | alarm latched; decoding continues, no further checks
module as13_out_decoder
  import as13_pkg::*;
#(
  parameter int HIST_W       = 8,
  parameter int ALARM_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [24:0]       y,
  output logic [3:0]        code_o,
  output logic              code_vld_o,
  output logic              illegal_o,
  output logic              trojan_o,
  output logic              alarm_o,
  input  logic [3:0]        hist_sel
`ifdef AS13_HIST_EN
  ,
  output logic [HIST_W-1:0] hist_o
`endif
);

  localparam int CNT_W = $clog2(ALARM_THRESH + 1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALARM_THRESH);

  logic [3:0]       match_code;
  logic             hit;

  state_t           state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic             code_vld_q, code_vld_d;
  logic             illegal_q, illegal_d;
  logic             trojan_q, trojan_d;
  logic             alarm_q, alarm_d;
  logic [3:0]       prev_code_q, prev_code_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             succ_bad;
  logic             thresh_hit;

  as13_pat_match u_match (
    .y    (y),
    .code (match_code),
    .hit  (hit)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    code_vld_d  = 1'b0;
    illegal_d   = 1'b0;
    trojan_d    = trojan_q;
    alarm_d     = alarm_q;
    prev_code_d = prev_code_q;
    prev_vld_d  = prev_vld_q;
    ill_cnt_d   = ill_cnt_q;
    succ_bad    = 1'b0;
    thresh_hit  = 1'b0;

    if (sample_en) begin
      code_vld_d = hit;
      illegal_d  = !hit;
      if (hit) begin
        code_d    = match_code;
        ill_cnt_d = '0;
      end else if (ill_cnt_q != THRESH) begin
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
      thresh_hit  = !hit && (ill_cnt_d == THRESH);
      succ_bad    = hit && prev_vld_q && (prev_code_q == CODE_P6) && !P6_SUCC_OK[match_code];
      // an illegal sample leaves no known predecessor for the next check
      prev_vld_d  = hit;
      prev_code_d = hit ? match_code : prev_code_q;
    end

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (sample_en) begin
          state_d = ST_RUN;
          if (succ_bad && (state_q == ST_RUN)) begin
            trojan_d = 1'b1;
            alarm_d  = 1'b1;
            state_d  = ST_ALARM;
          end
          if (thresh_hit) begin
            alarm_d = 1'b1;
            state_d = ST_ALARM;
          end
        end
      end
      ST_ALARM: state_d = ST_ALARM;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      code_vld_q  <= 1'b0;
      illegal_q   <= 1'b0;
      trojan_q    <= 1'b0;
      alarm_q     <= 1'b0;
      prev_code_q <= '0;
      prev_vld_q  <= 1'b0;
      ill_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      code_vld_q  <= code_vld_d;
      illegal_q   <= illegal_d;
      trojan_q    <= trojan_d;
      alarm_q     <= alarm_d;
      prev_code_q <= prev_code_d;
      prev_vld_q  <= prev_vld_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign code_o     = code_q;
  assign code_vld_o = code_vld_q;
  assign illegal_o  = illegal_q;
  assign trojan_o   = trojan_q;
  assign alarm_o    = alarm_q;

`ifdef AS13_HIST_EN
  logic [15:0][HIST_W-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (sample_en && hit && (hist_q[match_code] != '1)) begin
      hist_d[match_code] = hist_q[match_code] + HIST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q[hist_sel];
`else
  // histogram absent: hist_sel and HIST_W have no consumer in this build
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  localparam int unused_hist_w = HIST_W;
`endif

endmodule

// File: tb/tb_as13_out_decoder.sv
// Self-checking bench for as13_out_decoder: behavioural model compared every
// cycle plus directed literal checks. Histogram checks run when AS13_HIST_EN is defined.
module tb_as13_out_decoder;

  localparam int THRESH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_en = 1'b0;
  logic [24:0] y = '0;
  logic [3:0]  hist_sel = '0;
  logic [3:0]  code_o;
  logic        code_vld_o;
  logic        illegal_o;
  logic        trojan_o;
  logic        alarm_o;
`ifdef AS13_HIST_EN
  logic [7:0]  hist_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  as13_out_decoder #(.HIST_W(8), .ALARM_THRESH(THRESH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .y          (y),
    .code_o     (code_o),
    .code_vld_o (code_vld_o),
    .illegal_o  (illegal_o),
    .trojan_o   (trojan_o),
    .alarm_o    (alarm_o),
    .hist_sel   (hist_sel)
`ifdef AS13_HIST_EN
    ,
    .hist_o     (hist_o)
`endif
  );

  // ---------------- reference patterns from asserted y_i lists ----------------
  function automatic logic [24:0] mk(input int a, input int b = 0, input int c = 0,
                                     input int d = 0, input int e = 0, input int f = 0);
    int l[6];
    logic [24:0] v;
    l = '{a, b, c, d, e, f};
    v = '0;
    foreach (l[i]) if (l[i] > 0) v[l[i]-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [24:0] pat(input int k);
    case (k)
      1:  return mk(11);
      2:  return mk(2, 4, 5, 6, 7);
      3:  return mk(4, 5, 6, 7, 14, 23);
      4:  return mk(9, 17);
      5:  return mk(4, 8, 15, 16);
      6:  return mk(2, 3, 4, 19);
      7:  return mk(4, 7, 8, 24);
      8:  return mk(2, 4, 5, 6, 15);
      9:  return mk(9, 10);
      10: return mk(3, 4, 14, 21);
      11: return mk(2, 4, 7, 12);
      12: return mk(4, 16, 18, 20, 22);
      13: return mk(4, 5, 6, 13, 14);
      14: return mk(1, 2, 18, 25);
      15: return mk(2, 4, 18, 20);
      default: return '0;
    endcase
  endfunction

  function automatic int decode(input logic [24:0] v);
    for (int k = 0; k < 16; k++) if (v == pat(k)) return k;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0] code;
    logic       vld;
    logic       ill;
    logic       trojan;
    logic       alarm;
    logic       locked;
    logic       prev_vld;
    logic [3:0] prev_code;
    logic [7:0] ill_run;
  } mstate_t;

  mstate_t m = '0;
  int hist[16] = '{default: 0};

  function automatic mstate_t step(input mstate_t s, input logic en, input logic [24:0] v);
    mstate_t n;
    int k;
    n = s;
    n.vld = 1'b0;
    n.ill = 1'b0;
    if (!en) return n;
    k = decode(v);
    if (k < 0) begin
      n.ill = 1'b1;
      n.prev_vld = 1'b0;
      if (int'(s.ill_run) < THRESH) n.ill_run = s.ill_run + 8'd1;
      if (int'(n.ill_run) == THRESH) begin
        n.alarm  = 1'b1;
        n.locked = 1'b1;
      end
    end else begin
      n.vld     = 1'b1;
      n.code    = 4'(k);
      n.ill_run = 8'd0;
      if (!s.locked && s.prev_vld && s.prev_code == 4'd6 && !(k inside {[2:5]})) begin
        n.trojan = 1'b1;
        n.alarm  = 1'b1;
        n.locked = 1'b1;
      end
      n.prev_vld  = 1'b1;
      n.prev_code = 4'(k);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= '0;
      foreach (hist[i]) hist[i] <= 0;
    end else begin
      m <= step(m, sample_en, y);
      if (sample_en && decode(y) >= 0 && hist[decode(y)] < 255)
        hist[decode(y)] <= hist[decode(y)] + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("code_o", 32'(code_o), 32'(m.code));
    chk("code_vld_o", 32'(code_vld_o), 32'(m.vld));
    chk("illegal_o", 32'(illegal_o), 32'(m.ill));
    chk("trojan_o", 32'(trojan_o), 32'(m.trojan));
    chk("alarm_o", 32'(alarm_o), 32'(m.alarm));
`ifdef AS13_HIST_EN
    chk("hist_o", 32'(hist_o), 32'(hist[hist_sel]));
`endif
  end

  // ---------------- stimulus ----------------
  logic [24:0] ones = 25'h1FFFFFF;

  task automatic smp(input logic [24:0] v);
    sample_en = 1'b1;
    y = v;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    y = ones;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("gap code_vld_o", 32'(code_vld_o), 32'd0);
    end
  endtask

  task automatic do_reset();
    sample_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int order[16] = '{0, 1, 2, 3, 4, 6, 5, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset code_o", 32'(code_o), 32'd0);
    chk("reset alarm_o", 32'(alarm_o), 32'd0);

    // back-to-back legal samples
    smp(pat(1));  chk("p1 code", 32'(code_o), 32'd1); chk("p1 vld", 32'(code_vld_o), 32'd1);
    smp(pat(2));  chk("p2 code", 32'(code_o), 32'd2);
    smp(pat(7));  chk("p7 code", 32'(code_o), 32'd7);
    chk("p7 trojan", 32'(trojan_o), 32'd0);
    chk("p7 alarm", 32'(alarm_o), 32'd0);
    smp(ones);    chk("ill hold code", 32'(code_o), 32'd7); chk("ill flag", 32'(illegal_o), 32'd1);
    idle(1);      chk("idle illegal", 32'(illegal_o), 32'd0);

    // every pattern once, P6 followed by P5
    do_reset();
    foreach (order[i]) begin
      smp(pat(order[i]));
      chk("walk code", 32'(code_o), 32'(order[i]));
    end
    smp(pat(9) ^ mk(1)); chk("near miss illegal", 32'(illegal_o), 32'd1);

    // P6 successor rule
    do_reset();
    smp(pat(6)); smp(pat(5));  chk("p6p5 trojan", 32'(trojan_o), 32'd0);
    smp(pat(6)); smp(pat(12)); chk("p6p12 trojan", 32'(trojan_o), 32'd1);
    chk("p6p12 alarm", 32'(alarm_o), 32'd1);
    smp(pat(1)); chk("alarm decodes", 32'(code_o), 32'd1);
    smp(pat(6)); smp(pat(12)); chk("alarm sticky", 32'(alarm_o), 32'd1);

    // illegal run reaching threshold
    do_reset();
    smp(ones); chk("ill1 alarm", 32'(alarm_o), 32'd0);
    smp(ones); chk("ill2 alarm", 32'(alarm_o), 32'd0);
    smp(ones); chk("ill3 alarm", 32'(alarm_o), 32'd1); chk("ill3 flag", 32'(illegal_o), 32'd1);
    do_reset();
    smp(ones); smp(ones); smp(pat(1)); chk("clr alarm", 32'(alarm_o), 32'd0);
    smp(ones); smp(ones); chk("clr run alarm", 32'(alarm_o), 32'd0);
    smp(ones); chk("run3 alarm", 32'(alarm_o), 32'd1);

    // reset discards the predecessor
    do_reset();
    smp(pat(6));
    rst = 1'b0;
    #1;
    chk("async code_o", 32'(code_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    smp(pat(13));
    chk("post rst trojan", 32'(trojan_o), 32'd0);
    chk("post rst code", 32'(code_o), 32'd13);

    // idle gaps and illegal samples between P6 and its successor
    do_reset();
    smp(pat(6)); idle(4); smp(pat(3));
    chk("gap p3 trojan", 32'(trojan_o), 32'd0);
    smp(pat(6)); smp(ones); smp(pat(12));
    chk("ill break trojan", 32'(trojan_o), 32'd0);
    chk("ill break code", 32'(code_o), 32'd12);
    smp(pat(6)); idle(2); smp(pat(1));
    chk("gap p1 trojan", 32'(trojan_o), 32'd1);

`ifdef AS13_HIST_EN
    do_reset();
    repeat (300) smp(pat(4));
    hist_sel = 4'd4;
    #1;
    chk("hist p4 sat", 32'(hist_o), 32'd255);
    hist_sel = 4'd5;
    #1;
    chk("hist p5 zero", 32'(hist_o), 32'd0);
`endif

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/as13_out_decoder.md
AS13_OUT_DECODER -- requirements
Module: as13_out_decoder

Interface
REQ-001 Parameter HIST_W, default 8: width of each histogram counter.
REQ-002 Parameter ALARM_THRESH, default 3: number of consecutive illegal samples that latches the alarm.
REQ-003 clk  in  1: single clock; every register samples on the rising edge.
REQ-004 rst  in  1: reset, asynchronous and active-low.
REQ-005 sample_en  in  1: the y vector is valid this cycle.
REQ-006 y  in  25: as13 output word; bit i-1 carries y_i.
REQ-007 code_o  out  4: decoded pattern code.
REQ-008 code_vld_o  out  1: code_o holds a legal pattern.
REQ-009 illegal_o  out  1: the last sample matched no pattern.
REQ-010 trojan_o  out  1: sticky flag for a successor violation after P6.
REQ-011 alarm_o  out  1: sticky alarm.
REQ-012 hist_sel  in  4: histogram read index.
REQ-013 hist_o  out  HIST_W: count for hist_sel (present only with AS13_HIST_EN).

Function
REQ-014 The block SHALL decode y by exact match against 16 patterns (listed by asserted y bits):
- P0 none
- P1 {11}
- P2 {2,4,5,6,7}
- P3 {4,5,6,7,14,23}
- P4 {9,17}
- P5 {4,8,15,16}
- P6 {2,3,4,19}
- P7 {4,7,8,24}
- P8 {2,4,5,6,15}
- P9 {9,10}
- P10 {3,4,14,21}
- P11 {2,4,7,12}
- P12 {4,16,18,20,22}
- P13 {4,5,6,13,14}
- P14 {1,2,18,25}
- P15 {2,4,18,20}
REQ-015 On a cycle with sample_en=1, the block SHALL register code_o, code_vld_o and illegal_o with 1-cycle latency.
- On a match: code_vld_o=1, illegal_o=0.
- On no match: code_vld_o=0, illegal_o=1, and code_o holds its previous value.
REQ-016 On a cycle with sample_en=0, code_vld_o and illegal_o SHALL be 0 in the following cycle, and code_o SHALL hold.
REQ-017 The checker FSM SHALL have three states:
- IDLE: the first sample_en moves it to RUN.
- RUN: after each accepted sample it updates prev_code and prev_vld.
- ALARM: terminal until reset; decoding continues, successor checks stop.
REQ-018 In RUN, when prev_vld=1, prev_code=P6 and the current sample is legal with a code outside {P2,P3,P4,P5}, the block SHALL set trojan_o=1 (sticky) and go to ALARM.
REQ-019 The block SHALL keep a consecutive-illegal counter:
- increment on each illegal sample, saturating at ALARM_THRESH;
- clear on each legal sample;
- when it reaches ALARM_THRESH, set alarm_o=1 and go to ALARM.
REQ-020 The trojan_o=1 transition SHALL also set alarm_o=1 in the same cycle.
REQ-021 An illegal sample SHALL clear prev_vld, so no successor check is made against an unknown predecessor.
REQ-022 A sample that hits the threshold and violates the successor rule in the same cycle SHALL set both trojan_o and alarm_o.

Reset
REQ-023 Asserting rst SHALL immediately force:
- code_o=0, code_vld_o=0, illegal_o=0, trojan_o=0, alarm_o=0;
- FSM=IDLE, prev_vld=0, illegal counter=0;
- all histogram counters=0.
REQ-024 Reset asserted mid-sequence SHALL discard prev_code, so the first post-reset sample is never successor-checked.
REQ-025 Deassertion SHALL take effect at the next rising clk edge.

Configuration
REQ-026 With AS13_HIST_EN defined, the block SHALL keep 16 HIST_W-bit counters.
- Each legal sample increments the counter for its code, saturating at all-ones.
- hist_o is combinational: counter[hist_sel].
REQ-027 With AS13_HIST_EN undefined, the counters and the hist_o port SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package as13_pkg SHALL hold:
- the 4-bit code typedef;
- the 16 25-bit pattern constants;
- the FSM state enum;
- the P6-successor legal set.
REQ-029 The combinational matcher SHALL be the single sub-module as13_pat_match (y in, code and hit out); all sequential logic stays in as13_out_decoder.

Verification
REQ-030 Reset, then sample P1, P2, P7 back-to-back → code_o=1, 2, 7 on successive cycles, code_vld_o=1, trojan_o=0, alarm_o=0.
REQ-031 Sample P6 then P5 → trojan_o stays 0; sample P6 then P12 → trojan_o=1 and alarm_o=1 one cycle after the P12 sample; the FSM stays in ALARM.
REQ-032 Sample y=25'h1FFFFFF three times (ALARM_THRESH=3) → illegal_o=1 each time, alarm_o=1 after the third; with a legal sample after the second, the counter clears and alarm_o=0.
REQ-033 Sample P6, assert rst for 2 cycles, release, then sample P13 → trojan_o=0, code_o=13.
REQ-034 With AS13_HIST_EN and HIST_W=8, sample P4 300 times, hist_sel=4 → hist_o=255 (saturated); hist_sel=5 → 0.
REQ-035 Toggle sample_en=0 between P6 and P3 for 4 idle cycles → code_vld_o=0 during the gap and no trojan; insert an illegal sample between P6 and P12 instead → trojan_o=0.
